// File: rtl/rf_multiport_if.sv
// Decode/writeback bus of the multi-port register file: read ports, two write ports,
// issue strobe and the scoreboard outputs.
interface rf_multiport_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) ();
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] q;
  logic [NUM_RD-1:0]        q_busy;
  logic                     we0;
  logic [ADDR_W-1:0]        rw0;
  logic [DATA_W-1:0]        rd0;
  logic                     we1;
  logic [ADDR_W-1:0]        rw1;
  logic [DATA_W-1:0]        rd1;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_rw;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output ra, we0, rw0, rd0, we1, rw1, rd1, iss_en, iss_rw,
    input  q, q_busy, busy_cnt
  );

  modport slave (
    input  ra, we0, rw0, rd0, we1, rw1, rd1, iss_en, iss_rw,
    output q, q_busy, busy_cnt
  );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port register file with busy scoreboard; r0 reads as zero.
// Optional same-cycle write->read bypass enabled by defining RF_BYPASS_EN.
module rf_multiport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input logic          clk,
  input logic          reset,
  rf_multiport_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic [NUM_RD*DATA_W-1:0] q_all;
  logic [NUM_RD-1:0]        q_busy_all;
  logic [ADDR_W-1:0]        ra_k;

  always_comb begin
    regs_d = regs_q;
    // Port 1 is applied last so it wins a same-address collision.
    if (bus.we0 && bus.rw0 != '0) regs_d[bus.rw0] = bus.rd0;
    if (bus.we1 && bus.rw1 != '0) regs_d[bus.rw1] = bus.rd1;
  end

  always_comb begin
    busy_d = busy_q;
    if (bus.we0 && bus.rw0 != '0) busy_d[bus.rw0] = 1'b0;
    if (bus.we1 && bus.rw1 != '0) busy_d[bus.rw1] = 1'b0;
    // Issue after clear: a new producer in flight keeps the entry busy.
    if (bus.iss_en && bus.iss_rw != '0) busy_d[bus.iss_rw] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 1; i < Depth; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    q_all      = '0;
    q_busy_all = '0;
    ra_k       = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra_k                       = bus.ra[k*ADDR_W +: ADDR_W];
      q_all[k*DATA_W +: DATA_W] = regs_q[ra_k];
      q_busy_all[k]              = busy_q[ra_k];
`ifdef RF_BYPASS_EN
      if (bus.we0 && bus.rw0 == ra_k) begin
        q_all[k*DATA_W +: DATA_W] = bus.rd0;
        q_busy_all[k]              = 1'b0;
      end
      if (bus.we1 && bus.rw1 == ra_k) begin
        q_all[k*DATA_W +: DATA_W] = bus.rd1;
        q_busy_all[k]              = 1'b0;
      end
`endif
      if (ra_k == '0) begin
        q_all[k*DATA_W +: DATA_W] = '0;
        q_busy_all[k]              = 1'b0;
      end
    end
  end

  assign bus.q        = q_all;
  assign bus.q_busy   = q_busy_all;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_rf_multiport;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [DW-1:0] mdl_reg  [DEPTH];
  bit            mdl_busy [DEPTH];

  rf_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  function automatic int ra_of(int k);
    logic [AW-1:0] a;
    a = bus.ra[k*AW +: AW];
    return int'(a);
  endfunction

  function automatic logic [DW-1:0] exp_q(int k);
    int a;
    logic [DW-1:0] v;
    a = ra_of(k);
    v = mdl_reg[a];
    if (Bypass) begin
      if (bus.we0 && int'(bus.rw0) == a) v = bus.rd0;
      if (bus.we1 && int'(bus.rw1) == a) v = bus.rd1;
    end
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(int k);
    int a;
    logic b;
    a = ra_of(k);
    b = mdl_busy[a];
    if (Bypass && ((bus.we0 && int'(bus.rw0) == a) || (bus.we1 && int'(bus.rw1) == a))) b = 1'b0;
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mdl_busy[i]);
    return (AW+1)'(n);
  endfunction

  task automatic idle();
    bus.we0 = 0; bus.rw0 = '0; bus.rd0 = '0;
    bus.we1 = 0; bus.rw1 = '0; bus.rd1 = '0;
    bus.iss_en = 0; bus.iss_rw = '0;
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdl_reg[i]  = '0;
        mdl_busy[i] = 0;
      end
    end else begin
      if (bus.we0 && bus.rw0 != 0) begin
        mdl_reg[bus.rw0] = bus.rd0; mdl_busy[bus.rw0] = 0;
      end
      if (bus.we1 && bus.rw1 != 0) begin
        mdl_reg[bus.rw1] = bus.rd1; mdl_busy[bus.rw1] = 0;
      end
      if (bus.iss_en && bus.iss_rw != 0) mdl_busy[bus.iss_rw] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; idle(); bus.ra = '0;
    tick(); tick();
    reset = 0;
    bus.ra = {5'd31, 5'd5};
    #1;
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (bus.q[k*DW +: DW] !== 32'h0) begin
        errors++; $display("FAIL reset_q[%0d]: got %h want 0", k, bus.q[k*DW +: DW]);
      end
    end
    checks++;
    if (bus.q_busy !== 2'b00) begin
      errors++; $display("FAIL reset_qbusy: got %b want 00", bus.q_busy);
    end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", bus.busy_cnt);
    end
  endtask

  task automatic test_r0_guard();
    bus.we0 = 1; bus.rw0 = 5'd0; bus.rd0 = 32'hDEADBEEF;
    bus.iss_en = 1; bus.iss_rw = 5'd0;
    bus.ra = {5'd0, 5'd0};
    tick();
    idle(); #1;
    checks++;
    if (bus.q[0 +: DW] !== 32'h0) begin
      errors++; $display("FAIL r0_q: got %h want 0", bus.q[0 +: DW]);
    end
    checks++;
    if (bus.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL r0_cnt: got %0d want 0", bus.busy_cnt);
    end
  endtask

  task automatic test_dual_write();
    bus.we0 = 1; bus.rw0 = 5'd7; bus.rd0 = 32'h1111_1111;
    bus.we1 = 1; bus.rw1 = 5'd7; bus.rd1 = 32'h2222_2222;
    tick();
    idle(); bus.ra = {5'd0, 5'd7}; #1;
    checks++;
    if (bus.q[0 +: DW] !== 32'h2222_2222) begin
      errors++; $display("FAIL dual_write: got %h want 22222222", bus.q[0 +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    bus.ra = {5'd3, 5'd3};
    bus.we0 = 1; bus.rw0 = 5'd3; bus.rd0 = 32'hA5A5_0003;
    #1;
    want = Bypass ? 32'hA5A5_0003 : 32'h0;
    checks++;
    if (bus.q[0 +: DW] !== want) begin
      errors++; $display("FAIL bypass_same: got %h want %h", bus.q[0 +: DW], want);
    end
    tick();
    idle(); #1;
    checks++;
    if (bus.q[DW +: DW] !== 32'hA5A5_0003) begin
      errors++; $display("FAIL bypass_next: got %h want a5a50003", bus.q[DW +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    bus.iss_en = 1; bus.iss_rw = 5'd4; tick();
    bus.iss_rw = 5'd9; tick();
    idle(); bus.ra = {5'd9, 5'd4}; #1;
    checks++;
    if (bus.busy_cnt !== 6'd2) begin
      errors++; $display("FAIL sb_cnt2: got %0d want 2", bus.busy_cnt);
    end
    checks++;
    if (bus.q_busy !== 2'b11) begin
      errors++; $display("FAIL sb_qbusy: got %b want 11", bus.q_busy);
    end
    bus.iss_en = 1; bus.iss_rw = 5'd9;
    bus.we1 = 1; bus.rw1 = 5'd9; bus.rd1 = 32'h99;
    tick();
    idle(); #1;
    checks++;
    if (bus.busy_cnt !== 6'd2 || bus.q_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: got cnt=%0d busy9=%b want cnt=2 busy9=1",
               bus.busy_cnt, bus.q_busy[1]);
    end
    bus.we0 = 1; bus.rw0 = 5'd4; bus.rd0 = 32'h44;
    tick();
    idle(); #1;
    checks++;
    if (bus.busy_cnt !== 6'd1 || bus.q_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got cnt=%0d busy4=%b want cnt=1 busy4=0",
               bus.busy_cnt, bus.q_busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    bus.we0 = 1; bus.rw0 = 5'd4; bus.rd0 = 32'h55; tick();
    idle(); bus.iss_en = 1; bus.iss_rw = 5'd4; tick();
    idle(); bus.ra = {5'd4, 5'd4}; #1;
    checks++;
    if (bus.q[0 +: DW] !== 32'h55 || bus.q_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got q=%h busy=%b want q=55 busy=1", bus.q[0 +: DW], bus.q_busy[0]);
    end
    reset = 1; bus.we0 = 1; bus.rw0 = 5'd4; bus.rd0 = 32'h66;
    tick();
    reset = 0; idle(); #1;
    checks++;
    if (bus.q[0 +: DW] !== 32'h0 || bus.q_busy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset: got q=%h busy=%b cnt=%0d want 0/00/0",
               bus.q[0 +: DW], bus.q_busy, bus.busy_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(59) == 0);
      bus.we0    = $urandom_range(1);
      bus.rw0    = AW'($urandom_range(8));
      bus.rd0    = $urandom;
      bus.we1    = $urandom_range(1);
      bus.rw1    = AW'($urandom_range(8));
      bus.rd1    = $urandom;
      bus.iss_en = $urandom_range(1);
      bus.iss_rw = AW'($urandom_range(10));
      bus.ra     = {AW'($urandom_range(9)), AW'($urandom_range(9))};
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (bus.q[k*DW +: DW] !== exp_q(k) || bus.q_busy[k] !== exp_busy(k)) begin
          errors++;
          $display("FAIL rand_read[%0d] cyc %0d ra=%0d: got q=%h busy=%b want q=%h busy=%b",
                   k, c, ra_of(k), bus.q[k*DW +: DW], bus.q_busy[k], exp_q(k), exp_busy(k));
        end
      end
      checks++;
      if (bus.busy_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL rand_cnt cyc %0d: got %0d want %0d", c, bus.busy_cnt, exp_cnt());
      end
      tick();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1;
    idle();
    bus.ra = '0;
    test_reset();
    test_r0_guard();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
